reg_mport: RTL and testbench
============================

Name: reg_mport

Overview:
- Parametrised successor to the single-port register file: one write port plus NRD independent registered read ports.
- Writes and reads complete in the same cycle, with write-to-read bypass.
- A multi-cycle clear sequencer zeroes the array without asserting reset.
- Sits between the CPU decode/execute stages as the general-purpose register bank; per-port read enables let unused ports hold their value.

Parameters:
- BIT, 8, data width of each entry.
- SZB, 4, address width; depth SZA = 2**SZB.
- NRD, 2, number of read ports (1..4).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears array, outputs and FSM.
- we  in  1  write enable.
- waddr  in  SZB  write address.
- din  in  BIT  write data.
- ren  in  NRD  per-port read enable; bit i controls port i.
- raddr  in  NRD*SZB  read addresses; port i at [SZB*(i+1)-1 : SZB*i].
- dout  out  NRD*BIT  registered read data; port i at [BIT*(i+1)-1 : BIT*i].
- clr  in  1  request a clear sweep (single-cycle pulse or level).
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (asynchronous, active-high): all SZA entries = 0, dout = 0, busy = 0, FSM = IDLE, sweep pointer = 0. Takes effect immediately, regardless of clock.
- Write: with we=1, busy=0 and a rising clock, regf[waddr] <= din. Write-to-array latency is 1 cycle.
- Read, port i: with ren[i]=1 and busy=0, dout_i <= regf[raddr_i] on the rising clock. Latency is 1 cycle.
- Read hold: with ren[i]=0, dout_i holds its previous value.
- Bypass (write-first): if we=1, ren[i]=1 and raddr_i == waddr in the same cycle, dout_i <= din, not the old entry.
- Multiple read ports may share an address; every such port receives identical data.
- Reads and the write are independent. Unlike the previous generation, we=1 does not suppress reads.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when clr=1; pointer <= 0; busy goes high the following cycle.
  - SWEEP: each cycle regf[pointer] <= 0 and pointer <= pointer+1.
  - SWEEP -> IDLE on the cycle pointer == SZA-1 is written; busy falls on the next cycle.
  - A sweep therefore takes exactly SZA cycles with busy=1.
- While busy=1:
  - we is ignored; the write is dropped, not queued.
  - Any port with ren[i]=1 loads dout_i <= 0.
  - Ports with ren[i]=0 hold.
  - clr is ignored; no restart.
- clr and we asserted in the same IDLE cycle: the write is performed, and the sweep then clears it.
- Reset asserted mid-sweep: the FSM returns to IDLE and the array is fully cleared by reset.
- Pointer arithmetic is SZB bits, with no wrap beyond SZA-1 because the FSM exits there.

Optional Feature:
- Macro: REG_MPORT_ZERO_REG_EN.
- Defined: entry 0 is hardwired to zero.
  - Writes to waddr=0 are discarded.
  - Reads of raddr=0 return 0, including bypass when waddr=0.
  - The sweep still runs SZA cycles.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Shared definitions include file carries:
  - BIT_DATA and OFF, already present.
  - New FSM state encodings: REGF_IDLE = 1'b0, REGF_SWEEP = 1'b1.
- Sub-module reg_rdport: one registered read port with ren hold, bypass compare, busy-zero and the zero-register mux.
  - reg_mport instantiates it NRD times in a generate loop.
  - It reads the array through a flattened bus.

Test Plan:
- Reset, then write 0x5A to addr 3; next cycle read port 0 at addr 3 with ren=01 -> dout0 = 0x5A one cycle later; dout1 stays 0x00.
- we=1, waddr=7, din=0xC3, with raddr0=raddr1=7 and ren=11 in the same cycle -> dout0 = dout1 = 0xC3 next cycle (bypass).
- Fill all 16 entries with addr+0x10, then pulse clr:
  - busy is high for exactly 16 cycles.
  - A write of 0xFF to addr 2 during busy is dropped.
  - Afterwards every entry reads 0x00.
- Assert reset at sweep cycle 5 -> busy = 0 and dout = 0 immediately; all entries read 0; the next clr starts a full 16-cycle sweep.
- ren=00 after reading 0x5A: change raddr and write new data -> dout0 holds 0x5A.
- With REG_MPORT_ZERO_REG_EN defined: write 0x77 to addr 0, then read addr 0 -> 0x00. Same-cycle bypass to addr 0 -> 0x00.

Source files
------------

// File: rtl/reg_mport_pkg.sv
// Shared definitions for the multi-port register file.
package reg_mport_pkg;

  localparam int unsigned BIT_DATA = 8;
  localparam logic        OFF      = 1'b0;

  // Clear-sequencer state encodings, kept bit-compatible with the legacy include.
  localparam logic [0:0] REGF_IDLE  = 1'b0;
  localparam logic [0:0] REGF_SWEEP = 1'b1;

endpackage

// File: rtl/reg_mport_rdport.sv
// One registered read port: enable hold, write-first bypass, busy zeroing.
// Macro REG_MPORT_ZERO_REG_EN forces reads of entry 0 to zero.
module reg_rdport
  import reg_mport_pkg::*;
#(
  parameter int unsigned BIT = BIT_DATA,
  parameter int unsigned SZB = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ren,
  input  logic [SZB-1:0]            raddr,
  input  logic                      we,
  input  logic [SZB-1:0]            waddr,
  input  logic [BIT-1:0]            din,
  input  logic                      busy,
  input  logic [(2**SZB)*BIT-1:0]   regf,
  output logic [BIT-1:0]            dout
);

  localparam int unsigned SZA = 2**SZB;

  logic [SZA-1:0][BIT-1:0] arr;
  logic                    zero_sel;

  assign arr = regf;

`ifdef REG_MPORT_ZERO_REG_EN
  assign zero_sel = (raddr == '0);
`else
  assign zero_sel = OFF;
`endif

  // Busy and the hardwired zero entry take priority over the bypass path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (ren) begin
      if (busy || zero_sel)
        dout <= '0;
      else if (we && (raddr == waddr))
        dout <= din;
      else
        dout <= arr[raddr];
    end
  end

endmodule

// File: rtl/reg_mport.sv
// Register file with one write port, NRD registered read ports and a clear sweep.
// Macro REG_MPORT_ZERO_REG_EN hardwires entry 0 to zero.
module reg_mport
  import reg_mport_pkg::*;
#(
  parameter int unsigned BIT = BIT_DATA,
  parameter int unsigned SZB = 4,
  parameter int unsigned NRD = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [SZB-1:0]       waddr,
  input  logic [BIT-1:0]       din,
  input  logic [NRD-1:0]       ren,
  input  logic [NRD*SZB-1:0]   raddr,
  output logic [NRD*BIT-1:0]   dout,
  input  logic                 clr,
  output logic                 busy
);

  localparam int unsigned SZA = 2**SZB;

  logic [SZA-1:0][BIT-1:0] regf;
  logic [0:0]              state;
  logic [SZB-1:0]          ptr;
  logic                    wr_ok;

  assign busy = (state == REGF_SWEEP);

`ifdef REG_MPORT_ZERO_REG_EN
  assign wr_ok = we && (waddr != '0);
`else
  assign wr_ok = we;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regf  <= '0;
      state <= REGF_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        REGF_IDLE: begin
          if (wr_ok)
            regf[waddr] <= din;
          if (clr) begin
            state <= REGF_SWEEP;
            ptr   <= '0;
          end
        end
        REGF_SWEEP: begin
          regf[ptr] <= '0;
          ptr       <= ptr + 1'b1;
          if (ptr == '1)
            state <= REGF_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    reg_rdport #(
      .BIT(BIT),
      .SZB(SZB)
    ) u_rd (
      .clock (clock),
      .reset (reset),
      .ren   (ren[i]),
      .raddr (raddr[SZB*i +: SZB]),
      .we    (we),
      .waddr (waddr),
      .din   (din),
      .busy  (busy),
      .regf  (regf),
      .dout  (dout[BIT*i +: BIT])
    );
  end

endmodule

// File: tb/tb_reg_mport.sv
// Directed self-checking bench for reg_mport (BIT=8, SZB=4, NRD=2).
module tb_reg_mport;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we    = 1'b0;
  logic [3:0]  waddr = '0;
  logic [7:0]  din   = '0;
  logic [1:0]  ren   = '0;
  logic [3:0]  ra0   = '0;
  logic [3:0]  ra1   = '0;
  logic [7:0]  raddr;
  logic [15:0] dout;
  logic        clr   = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n;

  assign raddr = {ra1, ra0};

  always #5 clock = ~clock;

  reg_mport #(
    .BIT(8),
    .SZB(4),
    .NRD(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .din   (din),
    .ren   (ren),
    .raddr (raddr),
    .dout  (dout),
    .clr   (clr),
    .busy  (busy)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fill_val(input int unsigned a);
`ifdef REG_MPORT_ZERO_REG_EN
    if (a == 0) return 8'h00;
`endif
    return 8'(a + 8'h10);
  endfunction

  task automatic fill_all;
    ren = '0;
    for (int unsigned a = 0; a < 16; a++) begin
      we = 1'b1; waddr = 4'(a); din = 8'(a + 8'h10);
      tick;
    end
    we = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int unsigned a = 0; a < 16; a += 2) begin
      ren = 2'b11; ra0 = 4'(a); ra1 = 4'(a + 1);
      tick;
      check({tag, "_p0"}, dout[7:0], 8'h00);
      check({tag, "_p1"}, dout[15:8], 8'h00);
    end
    ren = '0;
  endtask

  initial begin
    // Reset state
    tick; tick;
    check("rst_dout", dout, 16'h0000);
    check("rst_busy", busy, 1'b0);
    #2 reset = 1'b0;

    // Basic write then read on port 0 only
    we = 1'b1; waddr = 4'd3; din = 8'h5A;
    tick;
    we = 1'b0; ren = 2'b01; ra0 = 4'd3;
    tick;
    check("rd_a3_p0", dout[7:0], 8'h5A);
    check("rd_a3_p1", dout[15:8], 8'h00);

    // Read hold with ren=00 while address and data change
    ren = 2'b00; ra0 = 4'd9; we = 1'b1; waddr = 4'd3; din = 8'h11;
    tick;
    check("hold_p0", dout[7:0], 8'h5A);

    // Same-cycle bypass to both ports
    we = 1'b1; waddr = 4'd7; din = 8'hC3; ren = 2'b11; ra0 = 4'd7; ra1 = 4'd7;
    tick;
    check("byp_p0", dout[7:0], 8'hC3);
    check("byp_p1", dout[15:8], 8'hC3);

    // Write does not suppress reads at other addresses
    we = 1'b1; waddr = 4'd4; din = 8'h44; ren = 2'b11; ra0 = 4'd3; ra1 = 4'd7;
    tick;
    check("rdw_p0", dout[7:0], 8'h11);
    check("rdw_p1", dout[15:8], 8'hC3);
    we = 1'b0; ren = 2'b01; ra0 = 4'd4;
    tick;
    check("rd_a4", dout[7:0], 8'h44);

    // Fill, spot-check, then sweep
    fill_all;
    ren = 2'b11; ra0 = 4'd0; ra1 = 4'd9;
    tick;
    check("fill_a0", dout[7:0], fill_val(0));
    check("fill_a9", dout[15:8], fill_val(9));
    ra0 = 4'd15; ra1 = 4'd14;
    tick;
    check("fill_a15", dout[7:0], 8'h1F);
    check("fill_a14", dout[15:8], 8'h1E);
    ren = 2'b00;

    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("busy_rise", busy, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      case (n)
        2: begin ren = 2'b01; ra0 = 4'd5; end
        3: begin
          check("busy_rd_p0", dout[7:0], 8'h00);
          check("busy_hold_p1", dout[15:8], 8'h1E);
          ren = 2'b00; clr = 1'b1;
        end
        4: clr = 1'b0;
        10: begin we = 1'b1; waddr = 4'd2; din = 8'hFF; end
        11: we = 1'b0;
        default: ;
      endcase
      tick;
    end
    check("sweep_len", n, 16);
    read_all_zero("swept");

    // Reset in the middle of a sweep
    fill_all;
    ren = 2'b11; ra0 = 4'd15; ra1 = 4'd14;
    tick;
    ren = 2'b00;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    tick; tick; tick; tick;
    check("mid_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_dout", dout, 16'h0000);
    #2 reset = 1'b0;
    read_all_zero("arst");

    // clr with a same-cycle write: write lands, then the sweep clears it
    we = 1'b1; waddr = 4'd6; din = 8'h66; clr = 1'b1;
    tick;
    we = 1'b0; clr = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    check("sweep2_len", n, 16);
    ren = 2'b01; ra0 = 4'd6;
    tick;
    check("clrwe_a6", dout[7:0], 8'h00);
    ren = 2'b00;

`ifdef REG_MPORT_ZERO_REG_EN
    we = 1'b1; waddr = 4'd0; din = 8'h77;
    tick;
    we = 1'b0; ren = 2'b01; ra0 = 4'd0;
    tick;
    check("zr_read", dout[7:0], 8'h00);
    we = 1'b1; waddr = 4'd0; din = 8'h77; ren = 2'b11; ra0 = 4'd0; ra1 = 4'd0;
    tick;
    we = 1'b0; ren = 2'b00;
    check("zr_byp_p0", dout[7:0], 8'h00);
    check("zr_byp_p1", dout[15:8], 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
